serial_word_collector: RTL

- Downstream stage of the bit-serial two's-complement datapath.
- Consumes the LSB-first serial bit stream produced by the serial complementer, delimited by a start-of-frame strobe.
- Reassembles each frame into a WIDTH-bit parallel word and presents it on a single-entry output register with a valid/ready handshake.
- Flags frame aborts and overruns so the parallel consumer can detect lost words.

---
 rtl/serial_word_collector.sv | 86 ++++++++
 1 files changed

// File: rtl/serial_word_collector.sv
// Reassembles an LSB-first, sof-delimited serial bit stream into WIDTH-bit words
// and holds each one in a single-entry valid/ready output register.
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             overrun_clr
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             done, abort;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        shreg_n = shreg;
        done    = 1'b0;
        abort   = 1'b0;
        if (in_valid) begin
            if (sof) begin
                // sof always restarts at bit 0; mid-frame it also aborts the partial word
                abort      = (state == COLLECT);
                shreg_n    = '0;
                shreg_n[0] = in;
                idx_n      = IW'(1);
                state_n    = COLLECT;
            end else if (state == COLLECT) begin
                shreg_n[idx] = in;
                if (idx == LAST) begin
                    done    = 1'b1;
                    idx_n   = '0;
                    state_n = IDLE;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            shreg      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            frame_err <= abort;
            // a completing word may replace the held one only if it is consumed at this edge
            if (done && (!word_valid || word_ready)) begin
                word_out   <= shreg_n;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (done && word_valid && !word_ready)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    assign busy = (state == COLLECT);

endmodule
